// File: rtl/sap_cpu.sv
// sap_cpu: parametrised accumulator CPU with internal synchronous program/data RAM,
// carry/zero flags, run/pause control and an idle-time RAM load port.
module sap_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic              o_illegal,
  output logic [ADDR_W-1:0] o_pc
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC = 4'h7,
                         OP_JZ = 4'h8, OP_OUT = 4'he, OP_HLT = 4'hf;
  typedef enum logic [1:0] {T0, T1, T2, T3} stage_t;
  stage_t            stage_q, stage_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic              c_q, c_d, z_q, z_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d, illegal_q, illegal_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand, raddr, waddr;
  logic [DATA_W-1:0] imm, wdata;
  logic [DATA_W:0]   alu;
  logic              prog_ok, ram_we;
  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {4'b0, ir_q[DATA_W-5:0]};
  assign run_d   = i_run;
  // A load coinciding with the rising edge of i_run is still taken; the fetch waits one cycle.
  assign prog_ok = stage_q == T0 && i_prog_we && (!i_run || halted_q || !run_q);
  assign ram_we  = prog_ok || (stage_q == T2 && opcode == OP_STA);
  assign waddr   = prog_ok ? i_prog_addr : operand;
  assign wdata   = prog_ok ? i_prog_data : a_q;
  assign raddr   = stage_q == T0 ? pc_q : operand;
  assign alu     = opcode == OP_SUB ? {1'b0, a_q} + {1'b0, ~rdata_q} + (DATA_W+1)'(1)
                                    : {1'b0, a_q} + {1'b0, rdata_q};
  always_ff @(posedge i_clk) begin
    if (ram_we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  always_comb begin
    stage_d     = stage_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    illegal_d   = 1'b0;
    case (stage_q)
      T0: stage_d = (!halted_q && i_run && !prog_ok) ? T1 : T0;
      T1: begin
        ir_d    = rdata_q;
        pc_d    = pc_q + ADDR_W'(1);
        stage_d = T2;
      end
      T2: begin
        stage_d = T0;
        case (opcode)
          OP_NOP, OP_STA: ;
          OP_LDA, OP_ADD, OP_SUB: stage_d = T3;
          OP_LDI: a_d = imm;
          OP_JMP: pc_d = operand;
          OP_JC:  pc_d = c_q ? operand : pc_q;
          OP_JZ:  pc_d = z_q ? operand : pc_q;
          OP_OUT: begin
            out_d       = a_q;
            out_valid_d = 1'b1;
          end
          OP_HLT: halted_d = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      T3: begin
        stage_d = T0;
        if (opcode == OP_LDA) a_d = rdata_q;
        else begin
          b_d = rdata_q;
          a_d = alu[DATA_W-1:0];
          c_d = alu[DATA_W];
          z_d = alu[DATA_W-1:0] == '0;
        end
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      stage_q     <= T0;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_q        <= ir_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      run_q       <= run_d;
    end
  assign o_out       = out_q;
  assign o_out_valid = out_valid_q;
  assign o_halted    = halted_q;
  assign o_illegal   = illegal_q;
  assign o_pc        = pc_q;
endmodule
